// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer and the tops that integrate it.
// The counter-width helper sizes the counters to the largest programmed interval.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    STRETCH,
    RELEASE,
    WAIT_DONE,
    RUN,
    FAULT
  } rs_state_t;

  localparam int DEF_N_SYNC         = 2;
  localparam int DEF_STRETCH_CYCLES = 16;
  localparam int DEF_NUM_STAGES     = 3;
  localparam int DEF_STAGE_GAP      = 8;
  localparam int DEF_DONE_TIMEOUT   = 1024;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (slave) and its environment (master).
// Level signals only; no handshake or backpressure.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = reset_seq_pkg::DEF_NUM_STAGES
);
  logic                  lock;
  logic                  init_done;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic                  fault;

  modport master (
    output lock, init_done, soft_rst_req,
    input  rst_out, ready, fault
  );

  modport slave (
    input  lock, init_done, soft_rst_req,
    output rst_out, ready, fault
  );
endinterface

// File: rtl/sync_reset.sv
// Reset synchronizer: asserts asynchronously, deasserts after N_SYNC clk edges.
// Latency: N_SYNC edges on release; no backpressure.
module sync_reset #(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  output logic o_rst_sync
);
  logic [N_SYNC-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], 1'b0};
    end
  end

  assign o_rst_sync = r_sync[N_SYNC-1];
endmodule

// File: rtl/reset_sequencer.sv
// Sequences stage resets after sync release + PLL lock, then waits for init_done or faults.
// Stage k releases N_SYNC+1+STRETCH_CYCLES+k*STAGE_GAP edges after rst falls; no backpressure.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_SYNC         = DEF_N_SYNC,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int DONE_TIMEOUT   = DEF_DONE_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  reset_sequencer_if.slave bus
);
  localparam int CW = cnt_width(STRETCH_CYCLES, STAGE_GAP, DONE_TIMEOUT);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(DONE_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_STAGES - 1);

  rs_state_t             r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_rst_out;
  logic                  r_ready;
  logic                  r_fault;
  logic                  r_lock_meta;
  logic                  r_lock_s;

  logic                  w_rst_sync;
  logic                  w_active;
  logic                  w_abort;
  logic [CW-1:0]         w_cnt_inc;

  sync_reset #(.N_SYNC(N_SYNC)) u_sync_reset (
    .clk        (clk),
    .rst        (rst),
    .o_rst_sync (w_rst_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= bus.lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Saturating increment; FAULT is the only state that ignores lock loss.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  assign w_active  = (r_state inside {STRETCH, RELEASE, WAIT_DONE, RUN});
  assign w_abort   = w_active && (!r_lock_s || bus.soft_rst_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else if (w_abort) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          r_rst_out <= '1;
          r_cnt     <= '0;
          r_idx     <= '0;
          if (!w_rst_sync && r_lock_s) begin
            r_state <= STRETCH;
          end
        end
        STRETCH: begin
          if (r_cnt == STRETCH_LAST) begin
            r_rst_out[0] <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= IW'(1);
            r_state      <= (NUM_STAGES == 1) ? WAIT_DONE : RELEASE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            r_rst_out[r_idx] <= 1'b0;
            r_cnt            <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= WAIT_DONE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT_DONE: begin
          if (bus.init_done) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state   <= FAULT;
            r_fault   <= 1'b1;
            r_rst_out <= '1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        FAULT: begin
          r_rst_out <= '1;
          if (bus.soft_rst_req) begin
            r_state <= HOLD;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state   <= HOLD;
          r_rst_out <= '1;
          r_ready   <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out = r_rst_out;
  assign bus.ready   = r_ready;
  assign bus.fault   = r_fault;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer at default parameters; edge 1 is the first clk edge after rst falls.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  typedef struct {
    int         edge_no;
    logic [4:0] val;      // {rst_out, ready, fault}
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   base  = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  reset_sequencer_if #(.NUM_STAGES(3)) dut_if ();

  reset_sequencer #(
    .N_SYNC         (2),
    .STRETCH_CYCLES (16),
    .NUM_STAGES     (3),
    .STAGE_GAP      (8),
    .DONE_TIMEOUT   (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_edge(input int k);
    while ((cyc - base) < k) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic push(input int e, input logic [2:0] ro, input logic rdy, input logic flt);
    ev_t ev;
    ev.edge_no = e;
    ev.val     = {ro, rdy, flt};
    exp_q.push_back(ev);
  endtask

  // Stage k falls at first + 8*k, lowest bit first.
  task automatic push_release(input int first);
    logic [2:0] ro;
    ro = 3'b111;
    for (int k = 0; k < 3; k++) begin
      ro = ro << 1;
      push(first + 8 * k, ro, 1'b0, 1'b0);
    end
  endtask

  // Compares every output change up to last_edge with the next queued event.
  task automatic sb_monitor(input int last_edge, input string tag);
    logic [4:0] prev;
    logic [4:0] cur;
    ev_t        e;
    prev = {dut_if.rst_out, dut_if.ready, dut_if.fault};
    while ((cyc - base) < last_edge) begin
      @(posedge clk);
      #1;
      cur = {dut_if.rst_out, dut_if.ready, dut_if.fault};
      if (cur !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s unexpected change: edge %0d out=%b, required no change", tag, cyc - base, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_no != (cyc - base) || e.val !== cur) begin
            fails++;
            $display("FAIL %s event: edge %0d out=%b, required edge %0d out=%b",
                     tag, cyc - base, cur, e.edge_no, e.val);
          end
        end
      end
      prev = cur;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s drain: %0d events pending, required 0 (next edge %0d out=%b)",
               tag, exp_q.size(), exp_q[0].edge_no, exp_q[0].val);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    dut_if.lock         = 1'b1;
    dut_if.init_done    = 1'b0;
    dut_if.soft_rst_req = 1'b0;
    #2;
    tests++; if (dut_if.rst_out !== 3'b111) begin fails++; $display("FAIL reset_rst_out: got %b required 111", dut_if.rst_out); end
    tests++; if (dut_if.ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", dut_if.ready); end
    tests++; if (dut_if.fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b required 0", dut_if.fault); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (dut_if.rst_out !== 3'b111) begin fails++; $display("FAIL reset_hold_rst_out: got %b required 111", dut_if.rst_out); end
    tests++; if (dut.r_state !== HOLD) begin fails++; $display("FAIL reset_hold_state: got %0d required %0d", dut.r_state, HOLD); end
  endtask

  task automatic test_sequence();
    dut_if.init_done = 1'b0;
    do_reset();
    push_release(19);
    push(41, 3'b000, 1'b1, 1'b0);
    fork
      sb_monitor(50, "sequence");
      begin
        wait_edge(40);
        dut_if.init_done = 1'b1;
      end
    join
    tests++; if (dut_if.ready !== 1'b1) begin fails++; $display("FAIL sequence_ready: got %b required 1", dut_if.ready); end
    dut_if.init_done = 1'b0;
  endtask

  task automatic test_fault();
    dut_if.init_done = 1'b0;
    do_reset();
    push_release(19);
    push(1059, 3'b111, 1'b0, 1'b1);
    push(1071, 3'b111, 1'b0, 1'b0);
    push_release(1088);
    fork
      sb_monitor(1110, "fault");
      begin
        wait_edge(1062); dut_if.lock = 1'b0;
        wait_edge(1064); dut_if.lock = 1'b1;
        wait_edge(1065); dut_if.init_done = 1'b1;
        wait_edge(1066); dut_if.init_done = 1'b0;
        wait_edge(1070); dut_if.soft_rst_req = 1'b1;
        wait_edge(1071); dut_if.soft_rst_req = 1'b0;
        tests++; if (dut.r_state !== HOLD) begin fails++; $display("FAIL fault_exit_state: got %0d required %0d", dut.r_state, HOLD); end
      end
    join
  endtask

  task automatic test_lock_loss();
    do_reset();
    push(19, 3'b110, 1'b0, 1'b0);
    push(27, 3'b100, 1'b0, 1'b0);
    push(33, 3'b111, 1'b0, 1'b0);
    push_release(59);
    fork
      sb_monitor(80, "lock_loss");
      begin
        wait_edge(30); dut_if.lock = 1'b0;
        wait_edge(34);
        tests++; if (dut.r_state !== HOLD) begin fails++; $display("FAIL lock_loss_state: got %0d required %0d", dut.r_state, HOLD); end
        wait_edge(40); dut_if.lock = 1'b1;
      end
    join
    tests++; if (dut_if.ready !== 1'b0) begin fails++; $display("FAIL lock_loss_ready: got %b required 0", dut_if.ready); end
  endtask

  task automatic test_back_to_back_soft();
    dut_if.init_done = 1'b0;
    do_reset();
    push_release(19);
    push(39, 3'b000, 1'b1, 1'b0);
    push(46, 3'b111, 1'b0, 1'b0);
    push_release(63);
    push(83, 3'b111, 1'b0, 1'b0);
    push_release(100);
    fork
      sb_monitor(120, "soft_req");
      begin
        wait_edge(38); dut_if.init_done = 1'b1;
        wait_edge(45); dut_if.soft_rst_req = 1'b1; dut_if.init_done = 1'b0;
        wait_edge(46); dut_if.soft_rst_req = 1'b0;
        tests++; if (dut.r_state !== HOLD) begin fails++; $display("FAIL soft_run_state: got %0d required %0d", dut.r_state, HOLD); end
        for (int k = 47; k <= 50; k++) begin
          wait_edge(k);
          dut_if.init_done = ~dut_if.init_done;
        end
        dut_if.init_done = 1'b0;
        wait_edge(82); dut_if.soft_rst_req = 1'b1; dut_if.init_done = 1'b1;
        wait_edge(83); dut_if.soft_rst_req = 1'b0; dut_if.init_done = 1'b0;
      end
    join
  endtask

  task automatic test_async_rst();
    dut_if.init_done = 1'b0;
    do_reset();
    wait_edge(10);
    #1;
    rst = 1'b1;
    #1;
    tests++; if (dut.r_state !== HOLD) begin fails++; $display("FAIL async_stretch_state: got %0d required %0d", dut.r_state, HOLD); end
    tests++; if (dut_if.rst_out !== 3'b111) begin fails++; $display("FAIL async_stretch_rst_out: got %b required 111", dut_if.rst_out); end
    do_reset();
    push_release(19);
    push(41, 3'b000, 1'b1, 1'b0);
    fork
      sb_monitor(45, "async_first");
      begin
        wait_edge(40); dut_if.init_done = 1'b1;
      end
    join
    #2;
    rst = 1'b1;
    #1;
    tests++; if (dut_if.rst_out !== 3'b111) begin fails++; $display("FAIL async_run_rst_out: got %b required 111", dut_if.rst_out); end
    tests++; if (dut_if.ready !== 1'b0) begin fails++; $display("FAIL async_run_ready: got %b required 0", dut_if.ready); end
    tests++; if (dut_if.fault !== 1'b0) begin fails++; $display("FAIL async_run_fault: got %b required 0", dut_if.fault); end
    dut_if.init_done = 1'b0;
    do_reset();
    push_release(19);
    push(41, 3'b000, 1'b1, 1'b0);
    fork
      sb_monitor(45, "async_again");
      begin
        wait_edge(40); dut_if.init_done = 1'b1;
      end
    join
    dut_if.init_done = 1'b0;
  endtask

  task automatic test_no_lock();
    dut_if.lock      = 1'b0;
    dut_if.init_done = 1'b0;
    do_reset();
    fork
      sb_monitor(200, "no_lock");
      begin
        wait_edge(20); dut_if.init_done = 1'b1;
        wait_edge(21); dut_if.init_done = 1'b0;
        wait_edge(60); dut_if.soft_rst_req = 1'b1;
        wait_edge(61); dut_if.soft_rst_req = 1'b0;
      end
    join
    tests++; if (dut_if.rst_out !== 3'b111) begin fails++; $display("FAIL no_lock_rst_out: got %b required 111", dut_if.rst_out); end
    tests++; if (dut_if.ready !== 1'b0) begin fails++; $display("FAIL no_lock_ready: got %b required 0", dut_if.ready); end
    tests++; if (dut_if.fault !== 1'b0) begin fails++; $display("FAIL no_lock_fault: got %b required 0", dut_if.fault); end
    tests++; if (dut.r_state !== HOLD) begin fails++; $display("FAIL no_lock_state: got %0d required %0d", dut.r_state, HOLD); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_fault();
    test_lock_loss();
    test_back_to_back_soft();
    test_async_rst();
    test_no_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
